hsid_sq_df_acc_ctrl: RTL and testbench
======================================

HSID_SQ_DF_ACC_CTRL -- requirements
Module: hsid_sq_df_acc_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default HSID_DATA_WIDTH, sets the band sample width.
REQ-002 Parameter DATA_WIDTH_ACC, default HSID_DATA_WIDTH_ACC, sets the accumulator/distance width.
REQ-003 Parameter HSP_LIBRARY_WIDTH, default HSID_HSP_LIBRARY_WIDTH, sets the reference index width.
REQ-004 Parameter HSP_BANDS_WIDTH, default HSID_HSP_BANDS_WIDTH, sets the band counter width.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-006 Control ports: start in 1; clear in 1; hsp_bands in HSP_BANDS_WIDTH (bands per vector); hsp_library_size in HSP_LIBRARY_WIDTH (reference count); busy out 1; done out 1; error out 1.
REQ-007 Sample stream ports: in_valid in 1; in_ready out 1; in_a in DATA_WIDTH (pixel band); in_b in DATA_WIDTH (library band).
REQ-008 Accumulator drive ports: acc_clear out 1; acc_initial_en out 1; acc_in_valid out 1; acc_in_a out DATA_WIDTH; acc_in_b out DATA_WIDTH; acc_in_last out 1; acc_in_ref out HSP_LIBRARY_WIDTH.
REQ-009 Accumulator return ports: acc_valid in 1; acc_value in DATA_WIDTH_ACC; acc_last in 1; acc_ref in HSP_LIBRARY_WIDTH; acc_of in 1.
REQ-010 Result ports: min_dist out DATA_WIDTH_ACC; min_ref out HSP_LIBRARY_WIDTH; min_valid out 1.

Function
REQ-011 The FSM SHALL have states IDLE, STREAM, DRAIN, DONE; busy = (STREAM or DRAIN).
REQ-012 IDLE->STREAM on start when hsp_bands!=0 and hsp_library_size!=0; config is latched on that edge; min_dist set to all-ones, min_valid=0.
REQ-013 start with hsp_bands==0 or hsp_library_size==0 SHALL go IDLE->DONE with error=1 and no accumulator traffic.
REQ-014 in_ready=1 only in STREAM; a sample is accepted on in_valid&&in_ready.
REQ-015 Each accepted sample SHALL be forwarded registered (1-cycle latency) as acc_in_valid=1 with acc_in_a/b=in_a/b; otherwise acc_in_valid=0.
REQ-016 A band counter (0..hsp_bands-1) and ref counter (0..hsp_library_size-1) advance per accepted sample; band wraps to 0 and ref increments after band hsp_bands-1.
REQ-017 acc_in_last=1 on the forwarded sample with band==hsp_bands-1; acc_in_ref=current ref counter; acc_initial_en=1 on band==0 with initial value 0.
REQ-018 STREAM->DRAIN on acceptance of the last band of the last reference; in_ready drops the following cycle.
REQ-019 Every acc_valid&&acc_last SHALL compare acc_value against min_dist: strictly smaller updates min_dist/min_ref and sets min_valid; ties keep the earlier ref.
REQ-020 A result with acc_of=1 SHALL be ignored for min tracking.
REQ-021 DRAIN->DONE when acc_valid&&acc_last arrives with acc_ref==hsp_library_size-1; done is a 1-cycle pulse; DONE->IDLE next cycle.
REQ-022 If all results overflowed, min_valid=0 and min_dist stays all-ones at done.
REQ-023 clear in any state SHALL return to IDLE next cycle, pulse acc_clear for 1 cycle, zero counters, drop in_ready/acc_in_valid, and hold min_* unchanged.
REQ-024 clear and start asserted together: clear wins.
REQ-025 start while busy SHALL be ignored.
REQ-026 error SHALL hold until the next accepted start or clear.

Reset
REQ-027 On rst_n low: state IDLE; busy, done, error, in_ready, acc_clear, acc_initial_en, acc_in_valid, acc_in_last, min_valid = 0; acc_in_a/b, acc_in_ref, min_ref, counters = 0; min_dist = all-ones.
REQ-028 Reset mid-STREAM SHALL abandon the run immediately; no done pulse.

Configuration
REQ-029 With HSID_SQ_DF_ACC_CTRL_MAX_EN defined, ports max_dist (DATA_WIDTH_ACC) and max_ref (HSP_LIBRARY_WIDTH) are added, tracking the largest non-overflow distance (reset/start 0, ties keep earlier); undefined, the ports and logic are absent.

Verification
REQ-030 bands=4, lib=3, continuous in_valid -> 12 acc_in_valid pulses, acc_in_last on samples 4/8/12, acc_in_ref 0,0,0,0,1,...,2.
REQ-031 Results 50,20,20 (ref 0,1,2) -> done pulse, min_dist=20, min_ref=1, min_valid=1.
REQ-032 Results 30(of=1),40,35 -> min_dist=35, min_ref=2; all three of=1 -> min_valid=0.
REQ-033 start with bands=0 -> DONE, error=1, acc_in_valid never asserted.
REQ-034 clear at sample 5 of 12 -> acc_clear 1-cycle pulse, IDLE next cycle, no done.
REQ-035 MAX_EN defined, results 5,9,9 -> max_dist=9, max_ref=1.

Source files
------------

// File: rtl/hsid_sq_df_acc_ctrl.sv
// rtl/hsid_sq_df_acc_ctrl.sv - squared-distance accumulator sequencer with min (and optional max, HSID_SQ_DF_ACC_CTRL_MAX_EN) tracking
`ifndef HSID_DATA_WIDTH
`define HSID_DATA_WIDTH 16
`endif
`ifndef HSID_DATA_WIDTH_ACC
`define HSID_DATA_WIDTH_ACC 32
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif

module hsid_sq_df_acc_ctrl #(
  parameter int DATA_WIDTH        = `HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_ACC    = `HSID_DATA_WIDTH_ACC,
  parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
  parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_a,
  input  logic [DATA_WIDTH-1:0]        in_b,
  output logic                         acc_clear,
  output logic                         acc_initial_en,
  output logic                         acc_in_valid,
  output logic [DATA_WIDTH-1:0]        acc_in_a,
  output logic [DATA_WIDTH-1:0]        acc_in_b,
  output logic                         acc_in_last,
  output logic [HSP_LIBRARY_WIDTH-1:0] acc_in_ref,
  input  logic                         acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0]    acc_value,
  input  logic                         acc_last,
  input  logic [HSP_LIBRARY_WIDTH-1:0] acc_ref,
  input  logic                         acc_of,
  output logic [DATA_WIDTH_ACC-1:0]    min_dist,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
  output logic                         min_valid
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
  ,
  output logic [DATA_WIDTH_ACC-1:0]    max_dist,
  output logic [HSP_LIBRARY_WIDTH-1:0] max_ref
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                       state;
  logic [HSP_BANDS_WIDTH-1:0]   bands_r;
  logic [HSP_BANDS_WIDTH-1:0]   band_cnt;
  logic [HSP_LIBRARY_WIDTH-1:0] lib_r;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_cnt;
  logic                         accept;
  logic                         band_last;
  logic                         ref_last;
  logic                         res_fire;
  logic                         res_ok;

  assign accept    = in_valid && in_ready;
  assign band_last = (band_cnt == bands_r - 1'b1);
  assign ref_last  = (ref_cnt == lib_r - 1'b1);
  assign res_fire  = acc_valid && acc_last;
  assign res_ok    = res_fire && !acc_of;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      in_ready       <= 1'b0;
      acc_clear      <= 1'b0;
      acc_initial_en <= 1'b0;
      acc_in_valid   <= 1'b0;
      acc_in_last    <= 1'b0;
      acc_in_a       <= '0;
      acc_in_b       <= '0;
      acc_in_ref     <= '0;
      bands_r        <= '0;
      lib_r          <= '0;
      band_cnt       <= '0;
      ref_cnt        <= '0;
      min_dist       <= '1;
      min_ref        <= '0;
      min_valid      <= 1'b0;
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
      max_dist       <= '0;
      max_ref        <= '0;
`endif
    end else begin
      acc_clear      <= 1'b0;
      done           <= 1'b0;
      acc_in_valid   <= 1'b0;
      acc_initial_en <= 1'b0;
      acc_in_last    <= 1'b0;
      if (clear) begin
        // Abort takes priority over everything, including a coincident start.
        state     <= IDLE;
        acc_clear <= 1'b1;
        busy      <= 1'b0;
        in_ready  <= 1'b0;
        error     <= 1'b0;
        band_cnt  <= '0;
        ref_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (hsp_bands == '0 || hsp_library_size == '0) begin
                state <= DONE;
                error <= 1'b1;
                done  <= 1'b1;
              end else begin
                state     <= STREAM;
                busy      <= 1'b1;
                in_ready  <= 1'b1;
                error     <= 1'b0;
                bands_r   <= hsp_bands;
                lib_r     <= hsp_library_size;
                band_cnt  <= '0;
                ref_cnt   <= '0;
                min_dist  <= '1;
                min_ref   <= '0;
                min_valid <= 1'b0;
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
                max_dist  <= '0;
                max_ref   <= '0;
`endif
              end
            end
          end
          STREAM: begin
            if (accept) begin
              acc_in_valid   <= 1'b1;
              acc_in_a       <= in_a;
              acc_in_b       <= in_b;
              acc_in_last    <= band_last;
              acc_in_ref     <= ref_cnt;
              acc_initial_en <= (band_cnt == '0);
              if (band_last) begin
                band_cnt <= '0;
                if (ref_last) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
                  ref_cnt  <= '0;
                end else begin
                  ref_cnt <= ref_cnt + 1'b1;
                end
              end else begin
                band_cnt <= band_cnt + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (res_fire && acc_ref == lib_r - 1'b1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // Strict compares keep the earliest reference on ties.
        if (busy && res_ok) begin
          if (acc_value < min_dist) begin
            min_dist  <= acc_value;
            min_ref   <= acc_ref;
            min_valid <= 1'b1;
          end
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
          if (acc_value > max_dist) begin
            max_dist <= acc_value;
            max_ref  <= acc_ref;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_hsid_sq_df_acc_ctrl.sv
// tb/tb_hsid_sq_df_acc_ctrl.sv - randomized bench for hsid_sq_df_acc_ctrl
module tb_hsid_sq_df_acc_ctrl;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, clear;
  logic [BW-1:0] hsp_bands;
  logic [LW-1:0] hsp_library_size;
  logic          busy, done, error;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          acc_clear, acc_initial_en, acc_in_valid, acc_in_last;
  logic [DW-1:0] acc_in_a, acc_in_b;
  logic [LW-1:0] acc_in_ref;
  logic          acc_valid, acc_last, acc_of;
  logic [AW-1:0] acc_value;
  logic [LW-1:0] acc_ref;
  logic [AW-1:0] min_dist;
  logic [LW-1:0] min_ref;
  logic          min_valid;
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
  logic [AW-1:0] max_dist;
  logic [LW-1:0] max_ref;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] rv[$];
  bit            rof[$];

  always #5 clk = ~clk;

  hsid_sq_df_acc_ctrl #(
    .DATA_WIDTH(DW), .DATA_WIDTH_ACC(AW), .HSP_LIBRARY_WIDTH(LW), .HSP_BANDS_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
    .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .acc_clear(acc_clear), .acc_initial_en(acc_initial_en), .acc_in_valid(acc_in_valid),
    .acc_in_a(acc_in_a), .acc_in_b(acc_in_b), .acc_in_last(acc_in_last), .acc_in_ref(acc_in_ref),
    .acc_valid(acc_valid), .acc_value(acc_value), .acc_last(acc_last), .acc_ref(acc_ref), .acc_of(acc_of),
    .min_dist(min_dist), .min_ref(min_ref), .min_valid(min_valid)
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
    , .max_dist(max_dist), .max_ref(max_ref)
`endif
  );

  task automatic idle_inputs();
    start = 0; clear = 0; hsp_bands = 0; hsp_library_size = 0;
    in_valid = 0; in_a = 0; in_b = 0;
    acc_valid = 0; acc_value = 0; acc_last = 0; acc_ref = 0; acc_of = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({busy, done, error, in_ready, acc_clear, acc_initial_en, acc_in_valid, acc_in_last, min_valid} !== 9'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000000",
        {busy, done, error, in_ready, acc_clear, acc_initial_en, acc_in_valid, acc_in_last, min_valid});
    end
    n_vec++;
    if ({acc_in_a, acc_in_b, acc_in_ref, min_ref} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", {acc_in_a, acc_in_b, acc_in_ref, min_ref});
    end
    n_vec++;
    if (min_dist !== {AW{1'b1}}) begin
      n_err++; $display("FAIL reset_min_dist: got %h expected all-ones", min_dist);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_error();
    int seen;
    for (int t = 0; t < 2; t++) begin
      seen = 0;
      hsp_bands = (t == 0) ? 8'd0 : 8'd4;
      hsp_library_size = (t == 0) ? 8'd3 : 8'd0;
      start = 1; in_valid = 1;
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 6; c++) begin
        if (acc_in_valid || in_ready) seen++;
        @(negedge clk);
      end
      n_vec++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL error_cfg%0d: got error=%b busy=%b expected error=1 busy=0", t, error, busy);
      end
      n_vec++;
      if (seen != 0) begin
        n_err++; $display("FAIL error_traffic%0d: got %0d traffic cycles expected 0", t, seen);
      end
    end
    in_valid = 0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (error !== 1'b1) begin
      n_err++; $display("FAIL error_hold: got %b expected 1", error);
    end
    clear = 1;
    @(negedge clk);
    clear = 0;
    n_vec++;
    if (error !== 1'b0) begin
      n_err++; $display("FAIL error_clear: got %b expected 0", error);
    end
    @(negedge clk);
  endtask

  task automatic test_run(input int bands, input int lib, input int pgap, input string nm);
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int qk[$];
    int resp_q[$];
    int acc_n, fwd_n, done_n, post, k, r;
    logic [AW-1:0] em, emx;
    logic [LW-1:0] er, erx;
    bit ev;
    logic [2*DW+2+LW-1:0] got, want;
    acc_n = 0; fwd_n = 0; done_n = 0; post = 0;
    hsp_bands = BW'(bands); hsp_library_size = LW'(lib); start = 1;
    @(negedge clk);
    for (int c = 0; c < 4000 && post < 3; c++) begin
      if (acc_in_valid) begin
        fwd_n++;
        n_vec++;
        if (qk.size() == 0) begin
          n_err++; $display("FAIL %s extra_fwd: got acc_in_valid expected no pending sample", nm);
        end else begin
          k = qk.pop_front();
          want = {qa.pop_front(), qb.pop_front(), (k % bands) == bands - 1, (k % bands) == 0, LW'(k / bands)};
          got  = {acc_in_a, acc_in_b, acc_in_last, acc_initial_en, acc_in_ref};
          if (got !== want) begin
            n_err++; $display("FAIL %s fwd[%0d]: got %h expected %h", nm, k, got, want);
          end
          if ((k % bands) == bands - 1) resp_q.push_back(k / bands);
        end
      end
      if (done) done_n++;
      if (done_n > 0) post++;
      // Random restarts and config changes while busy must be ignored.
      if (done_n == 0) begin
        start = ($urandom % 8 == 0);
        hsp_bands = BW'($urandom);
        hsp_library_size = LW'($urandom);
      end else begin
        start = 0;
      end
      in_valid = (pgap == 0) ? 1'b1 : ($urandom % pgap != 0);
      in_a = DW'($urandom); in_b = DW'($urandom);
      if (in_valid && in_ready) begin
        qa.push_back(in_a); qb.push_back(in_b); qk.push_back(acc_n); acc_n++;
      end
      if (resp_q.size() > 0 && $urandom % 2 == 0) begin
        r = resp_q.pop_front();
        acc_valid = 1; acc_last = 1; acc_ref = LW'(r);
        acc_value = (r < rv.size()) ? rv[r] : '0;
        acc_of = (r < rof.size()) ? rof[r] : 1'b1;
      end else if ($urandom % 4 == 0) begin
        acc_valid = 1; acc_last = 0; acc_value = 0; acc_of = 0; acc_ref = LW'($urandom);
      end else begin
        acc_valid = 0; acc_last = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
    n_vec++;
    if (acc_n != bands * lib || fwd_n != bands * lib) begin
      n_err++; $display("FAIL %s sample_count: got accepted=%0d forwarded=%0d expected %0d", nm, acc_n, fwd_n, bands * lib);
    end
    n_vec++;
    if (done_n != 1) begin
      n_err++; $display("FAIL %s done_pulse: got %0d done cycles expected 1", nm, done_n);
    end
    em = '1; er = '0; ev = 0; emx = '0; erx = '0;
    for (int i = 0; i < lib; i++) begin
      if (!rof[i] && rv[i] < em) begin em = rv[i]; er = LW'(i); ev = 1; end
      if (!rof[i] && rv[i] > emx) begin emx = rv[i]; erx = LW'(i); end
    end
    n_vec++;
    if (min_dist !== em || min_ref !== er || min_valid !== ev) begin
      n_err++; $display("FAIL %s min: got %0d/%0d/%b expected %0d/%0d/%b", nm, min_dist, min_ref, min_valid, em, er, ev);
    end
`ifdef HSID_SQ_DF_ACC_CTRL_MAX_EN
    n_vec++;
    if (max_dist !== emx || max_ref !== erx) begin
      n_err++; $display("FAIL %s max: got %0d/%0d expected %0d/%0d", nm, max_dist, max_ref, emx, erx);
    end
`endif
    n_vec++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s end_flags: got error=%b busy=%b expected 0/0", nm, error, busy);
    end
  endtask

  task automatic test_clear();
    int bad;
    bad = 0;
    hsp_bands = 4; hsp_library_size = 3; start = 1;
    @(negedge clk);
    start = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin acc_valid = 1; acc_last = 1; acc_value = 77; acc_of = 0; acc_ref = 0; end
      else acc_valid = 0;
      @(negedge clk);
    end
    acc_valid = 0; acc_last = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    n_vec++;
    if ({acc_clear, busy, in_ready, acc_in_valid} !== 4'b1000) begin
      n_err++; $display("FAIL clear_pulse: got clr/busy/rdy/fwd=%b expected 1000", {acc_clear, busy, in_ready, acc_in_valid});
    end
    n_vec++;
    if (min_dist !== 77 || min_valid !== 1'b1) begin
      n_err++; $display("FAIL clear_min_hold: got %0d/%b expected 77/1", min_dist, min_valid);
    end
    @(negedge clk);
    n_vec++;
    if (acc_clear !== 1'b0) begin
      n_err++; $display("FAIL clear_width: got %b expected 0", acc_clear);
    end
    for (int c = 0; c < 20; c++) begin
      if (done || acc_in_valid) bad++;
      @(negedge clk);
    end
    in_valid = 0;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL clear_no_done: got %0d activity cycles expected 0", bad);
    end
    hsp_bands = 4; hsp_library_size = 3; start = 1; clear = 1;
    @(negedge clk);
    start = 0; clear = 0;
    n_vec++;
    if ({acc_clear, busy, in_ready} !== 3'b100) begin
      n_err++; $display("FAIL clear_beats_start: got clr/busy/rdy=%b expected 100", {acc_clear, busy, in_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    hsp_bands = 4; hsp_library_size = 3; start = 1;
    @(negedge clk);
    start = 0; in_valid = 1;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    n_vec++;
    if ({busy, in_ready, acc_in_valid} !== 3'b000 || min_dist !== {AW{1'b1}}) begin
      n_err++; $display("FAIL reset_mid: got busy/rdy/fwd=%b min=%h expected 000 all-ones", {busy, in_ready, acc_in_valid}, min_dist);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      if (done || acc_in_valid) bad++;
      @(negedge clk);
    end
    in_valid = 0;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL reset_mid_quiet: got %0d activity cycles expected 0", bad);
    end
  endtask

  initial begin
    int b, l;
    test_reset();
    test_error();
    rv = '{50, 20, 20}; rof = '{0, 0, 0};
    test_run(4, 3, 0, "min_tie");
    rv = '{30, 40, 35}; rof = '{1, 0, 0};
    test_run(4, 3, 3, "overflow_skip");
    rv = '{30, 40, 35}; rof = '{1, 1, 1};
    test_run(4, 3, 0, "all_overflow");
    rv = '{5, 9, 9}; rof = '{0, 0, 0};
    test_run(4, 3, 2, "max_tie");
    test_clear();
    test_reset_mid();
    for (int n = 0; n < 6; n++) begin
      b = 1 + $urandom % 6;
      l = 1 + $urandom % 5;
      rv.delete(); rof.delete();
      for (int i = 0; i < l; i++) begin
        rv.push_back(AW'($urandom % 100));
        rof.push_back($urandom % 5 == 0);
      end
      test_run(b, l, (n % 2 == 0) ? 0 : 3, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
